// File: rtl/vga_grid_pkg.sv
// Shared constants for the 28x28 drawing grid: geometry, cell colours and
// the scheduler state encoding.
package vga_grid_pkg;

  localparam int GRID_SIZE     = 28;
  localparam int PIXEL_SIZE    = 4;
  localparam int PIX_W         = $clog2(PIXEL_SIZE);
  localparam int GRID_OFFSET_X = 10;
  localparam int GRID_OFFSET_Y = 10;
  localparam int GRID_CELLS    = GRID_SIZE * GRID_SIZE;

  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_DRAW  = 3'd3;
  localparam logic [2:0] ST_NEXT  = 3'd4;

  // The cursor highlight overrides the painted state of the cell.
  function automatic logic [2:0] pick_colour(input logic on_cursor, input logic painted);
    if (on_cursor) return COL_RED;
    else if (painted) return COL_BLACK;
    else return COL_WHITE;
  endfunction

endpackage

// File: rtl/grid_cell_painter.sv
// Emits one PIXEL_SIZE x PIXEL_SIZE block of framebuffer plots for a cell,
// x offset fastest; done marks the final plot of the block.
module grid_cell_painter
  import vga_grid_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [4:0] cx,
  input  logic [4:0] cy,
  input  logic [2:0] colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       done
);

  logic [PIX_W-1:0] px;
  logic [PIX_W-1:0] py;

  assign done = vga_plot && (px == '1) && (py == '1);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      px         <= '0;
      py         <= '0;
    end else if (start) begin
      vga_x      <= 8'(GRID_OFFSET_X) + (8'(cx) << PIX_W);
      vga_y      <= 7'(GRID_OFFSET_Y) + (7'(cy) << PIX_W);
      vga_colour <= colour;
      vga_plot   <= 1'b1;
      px         <= '0;
      py         <= '0;
    end else if (vga_plot) begin
      // Coordinates stay on the last plotted pixel once the block completes.
      if (done) begin
        vga_plot <= 1'b0;
      end else if (px == '1) begin
        px    <= '0;
        py    <= py + 1'b1;
        vga_x <= vga_x - 8'(PIXEL_SIZE - 1);
        vga_y <= vga_y + 1'b1;
      end else begin
        px    <= px + 1'b1;
        vga_x <= vga_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/grid_plot_scheduler.sv
// Arbitrates full-grid redraws and single-cell updates onto the single
// vga_adapter plot port, fetching each cell's painted flag before drawing.
module grid_plot_scheduler
  import vga_grid_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       redraw_req,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [4:0] upd_x,
  input  logic [4:0] upd_y,
  input  logic [4:0] cursor_x,
  input  logic [4:0] cursor_y,
  output logic [9:0] mem_addr,
  input  logic       mem_rdata,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       redraw_done
);

  logic [2:0] state;
  logic       full_mode;
  logic       pending;
  logic       rdy_en;
  logic       oob;
  logic [4:0] cx;
  logic [4:0] cy;
  logic       last_cell;
  logic       paint_start;
  logic       painter_done;
  logic [2:0] cell_colour;

  assign busy        = (state != ST_IDLE);
  // rdy_en keeps upd_ready low until the first clock after reset release.
  assign upd_ready   = rdy_en && (state == ST_IDLE) && !pending && !redraw_req;
  assign last_cell   = (cx == 5'(GRID_SIZE - 1)) && (cy == 5'(GRID_SIZE - 1));
  assign redraw_done = (state == ST_NEXT) && last_cell && !pending;
  assign paint_start = (state == ST_LATCH) && !oob;
  assign cell_colour = pick_colour((cx == cursor_x) && (cy == cursor_y), mem_rdata);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      full_mode <= 1'b0;
      pending   <= 1'b0;
      rdy_en    <= 1'b0;
      oob       <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      mem_addr  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (redraw_req) pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pending || redraw_req) begin
            full_mode <= 1'b1;
            pending   <= 1'b0;
            oob       <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            mem_addr  <= '0;
            state     <= ST_FETCH;
          end else if (upd_valid && upd_ready) begin
            full_mode <= 1'b0;
            oob       <= (upd_x >= 5'(GRID_SIZE)) || (upd_y >= 5'(GRID_SIZE));
            cx        <= upd_x;
            cy        <= upd_y;
            mem_addr  <= 10'(upd_y) * 10'(GRID_SIZE) + 10'(upd_x);
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        // Out-of-grid updates are dropped here without plotting.
        ST_LATCH: state <= oob ? ST_IDLE : ST_DRAW;
        ST_DRAW: begin
          if (painter_done) state <= full_mode ? ST_NEXT : ST_IDLE;
        end
        ST_NEXT: begin
          if (pending) begin
            pending  <= redraw_req;
            cx       <= '0;
            cy       <= '0;
            mem_addr <= '0;
            state    <= ST_FETCH;
          end else if (last_cell) begin
            state <= ST_IDLE;
          end else begin
            // Row-major walk, so the memory address simply increments.
            if (cx == 5'(GRID_SIZE - 1)) begin
              cx <= '0;
              cy <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
            mem_addr <= mem_addr + 1'b1;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  grid_cell_painter u_painter (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .start      (paint_start),
    .cx         (cx),
    .cy         (cy),
    .colour     (cell_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .done       (painter_done)
  );

endmodule

// File: tb/tb_grid_plot_scheduler.sv
// Directed bench for grid_plot_scheduler: cell updates, full redraws,
// redraw restart, out-of-grid updates and asynchronous reset.
module tb_grid_plot_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       redraw_req = 1'b0;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [4:0] upd_x = '0;
  logic [4:0] upd_y = '0;
  logic [4:0] cursor_x = 5'd14;
  logic [4:0] cursor_y = 5'd14;
  logic [9:0] mem_addr;
  logic       mem_rdata = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       redraw_done;

  bit mem [784];

  int nvec = 0;
  int nerr = 0;

  int plot_cnt = 0;
  int nonwhite = 0;
  int done_cnt = 0;
  int rdy_busy = 0;
  int acc_cnt = 0;
  int hits [784];

  grid_plot_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .redraw_req  (redraw_req),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_x       (upd_x),
    .upd_y       (upd_y),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .busy        (busy),
    .redraw_done (redraw_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Pixel memory: read data one cycle after the address.
  always @(posedge CLOCK_50)
    mem_rdata <= (int'(mem_addr) < 784) ? mem[int'(mem_addr)] : 1'b0;

  initial for (int i = 0; i < 784; i++) hits[i] = 0;

  always @(negedge CLOCK_50) begin
    if (vga_plot) begin
      int c;
      plot_cnt++;
      if (vga_colour != 3'b111) nonwhite++;
      c = ((int'(vga_y) - 10) / 4) * 28 + (int'(vga_x) - 10) / 4;
      if (c >= 0 && c < 784) hits[c]++;
    end
    if (redraw_done) done_cnt++;
    if (busy && upd_ready) rdy_busy++;
    if (upd_valid && upd_ready) acc_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_cell(input int x, input int y, input logic [2:0] col, input string tag);
    logic [18:0] exp;
    upd_x = 5'(x);
    upd_y = 5'(y);
    upd_valid = 1'b1;
    #1;
    check({tag, " ready"}, 32'(upd_ready), 32'd1);
    step;
    upd_valid = 1'b0;
    check({tag, " busy_fetch"}, 32'(busy), 32'd1);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(y * 28 + x));
    step;
    check({tag, " no_plot_latch"}, 32'(vga_plot), 32'd0);
    for (int k = 0; k < 16; k++) begin
      step;
      exp = {1'b1, 8'(10 + 4 * x + k % 4), 7'(10 + 4 * y + k / 4), col};
      check({tag, " plot"}, 32'({vga_plot, vga_x, vga_y, vga_colour}), 32'(exp));
    end
    step;
    check({tag, " end"}, 32'({vga_plot, busy, upd_ready}), 32'(3'b001));
    check({tag, " hold_x"}, 32'(vga_x), 32'(10 + 4 * x + 3));
  endtask

  initial begin
    int n;
    int base_plot, base_done, base_nw, base_rdy, base_acc, bad;
    int hbase [784];

    // Reset state
    step;
    check("rst plot", 32'(vga_plot), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready", 32'(upd_ready), 32'd0);
    check("rst done", 32'(redraw_done), 32'd0);
    check("rst xy", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    check("rst addr", 32'(mem_addr), 32'd0);
    step;
    resetn = 1'b1;
    #1;
    check("rel ready_low", 32'(upd_ready), 32'd0);
    step;
    check("rel ready_high", 32'(upd_ready), 32'd1);

    // Single-cell updates
    cursor_x = 5'd14; cursor_y = 5'd14;
    do_cell(0, 0, 3'b111, "cell00");
    do_cell(14, 14, 3'b100, "cell_cursor");
    mem[61] = 1'b1;
    do_cell(5, 2, 3'b000, "cell52");
    mem[61] = 1'b0;

    // Out-of-grid update: accepted, two busy cycles, no plots
    base_plot = plot_cnt;
    upd_x = 5'd28; upd_y = 5'd3; upd_valid = 1'b1;
    #1;
    check("oob ready", 32'(upd_ready), 32'd1);
    step;
    upd_valid = 1'b0;
    check("oob busy1", 32'(busy), 32'd1);
    step;
    check("oob busy2", 32'(busy), 32'd1);
    step;
    check("oob idle", 32'({busy, upd_ready}), 32'(2'b01));
    check("oob plots", 32'(plot_cnt - base_plot), 32'd0);

    // Full redraw, memory all clear, cursor off-grid
    cursor_x = 5'd31; cursor_y = 5'd31;
    base_plot = plot_cnt; base_done = done_cnt; base_nw = nonwhite; base_rdy = rdy_busy;
    for (int i = 0; i < 784; i++) hbase[i] = hits[i];
    redraw_req = 1'b1;
    #1;
    check("full ready_req", 32'(upd_ready), 32'd0);
    step;
    redraw_req = 1'b0;
    n = 1;
    while (busy && n < 20000) begin
      step;
      n++;
    end
    check("full cycles", 32'(n), 32'd14897);
    check("full plots", 32'(plot_cnt - base_plot), 32'd12544);
    check("full colour", 32'(nonwhite - base_nw), 32'd0);
    check("full done", 32'(done_cnt - base_done), 32'd1);
    check("full ready_busy", 32'(rdy_busy - base_rdy), 32'd0);
    bad = 0;
    for (int i = 0; i < 784; i++) if (hits[i] - hbase[i] != 16) bad++;
    check("full hits", 32'(bad), 32'd0);
    check("full ready_end", 32'(upd_ready), 32'd1);

    // Redraw restarted at plot 5000 with an update held pending
    base_plot = plot_cnt; base_done = done_cnt; base_nw = nonwhite;
    base_rdy = rdy_busy; base_acc = acc_cnt;
    for (int i = 0; i < 784; i++) hbase[i] = hits[i];
    upd_x = 5'd3; upd_y = 5'd3; upd_valid = 1'b1;
    redraw_req = 1'b1;
    #1;
    check("rst2 ready_req", 32'(upd_ready), 32'd0);
    step;
    redraw_req = 1'b0;
    n = 0;
    while ((plot_cnt - base_plot) < 5000 && n < 10000) begin
      step;
      n++;
    end
    check("rst2 plot5000", 32'(plot_cnt - base_plot), 32'd5000);
    redraw_req = 1'b1;
    step;
    redraw_req = 1'b0;
    n = 0;
    while (busy && n < 20000) begin
      step;
      n++;
    end
    check("rst2 plots", 32'(plot_cnt - base_plot), 32'd17552);
    check("rst2 done", 32'(done_cnt - base_done), 32'd1);
    check("rst2 colour", 32'(nonwhite - base_nw), 32'd0);
    check("rst2 ready_busy", 32'(rdy_busy - base_rdy), 32'd0);
    check("rst2 accept_idle", 32'(acc_cnt - base_acc), 32'd1);
    bad = 0;
    for (int i = 0; i < 784; i++)
      if (hits[i] - hbase[i] != ((i <= 312) ? 32 : 16)) bad++;
    check("rst2 hits", 32'(bad), 32'd0);
    step;
    upd_valid = 1'b0;
    check("held upd busy", 32'(busy), 32'd1);
    for (int k = 0; k < 18; k++) step;
    check("held upd plots", 32'(plot_cnt - base_plot), 32'd17568);
    check("held upd idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a cell draw
    base_plot = plot_cnt;
    upd_x = 5'd7; upd_y = 5'd9; upd_valid = 1'b1;
    step;
    upd_valid = 1'b0;
    for (int k = 0; k < 6; k++) step;
    check("mid draw plot", 32'(vga_plot), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid rst plot", 32'(vga_plot), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst ready", 32'(upd_ready), 32'd0);
    check("mid rst x", 32'(vga_x), 32'd0);
    step;
    resetn = 1'b1;
    base_plot = plot_cnt;
    step;
    check("mid rel ready", 32'(upd_ready), 32'd1);
    for (int k = 0; k < 5; k++) step;
    check("mid rel no_plot", 32'(plot_cnt - base_plot), 32'd0);
    check("mid rel idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/grid_plot_scheduler.md
Name: grid_plot_scheduler

Overview:
- Sequences all framebuffer writes to vga_adapter for the 28x28 drawing grid. Two request sources share the single plot port: full-grid redraws and single-cell updates (cursor moved, cell painted).
- Reads cell state from the pixel-memory read port, picks the cell colour, and emits one 4x4 block of plots per cell.
- Sits between the cursor/paint logic and vga_adapter, and replaces the ad-hoc background drawer.

Parameters:
- GRID_SIZE, 28, cells per row/column
- PIXEL_SIZE, 4, screen pixels per cell edge (power of two)
- GRID_OFFSET_X, 10, screen x of cell (0,0)
- GRID_OFFSET_Y, 10, screen y of cell (0,0)

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- redraw_req  in  1  one-cycle pulse: repaint whole grid
- upd_valid  in  1  single-cell update request
- upd_ready  out  1  update accepted when upd_valid&upd_ready
- upd_x, upd_y  in  5 each  cell coordinates of update
- cursor_x, cursor_y  in  5 each  live cursor cell
- mem_addr  out  10  pixel-memory read address = y*GRID_SIZE+x
- mem_rdata  in  1  cell painted flag, valid 1 cycle after mem_addr
- vga_x  out  8  plot x
- vga_y  out  7  plot y
- vga_colour  out  3  plot colour {R,G,B}
- vga_plot  out  1  framebuffer write strobe
- busy  out  1  high in any state except IDLE
- redraw_done  out  1  one-cycle pulse after last plot of a full redraw

Behaviour:
- Reset, asynchronous and immediate, also mid-operation: state IDLE; all outputs 0; redraw pending flag cleared. Exception: upd_ready returns to 1 on the first clock after reset release. Any partially drawn cell is abandoned.
- States:
  - IDLE
  - FETCH: mem_addr registered
  - LATCH: mem_rdata and cursor sampled, colour fixed
  - DRAW: 16 cycles, vga_plot=1
  - NEXT: full-mode cell advance
- IDLE priority:
  - A pending redraw wins: go to FETCH with cell (0,0), mode FULL.
  - Otherwise, if upd_valid, accept: go to FETCH, mode CELL.
  - upd_ready = (state==IDLE) and no redraw pending and redraw_req==0.
- Colour, decided in LATCH:
  - cell==cursor → 3'b100 (red)
  - else mem_rdata==1 → 3'b000 (black)
  - else 3'b111 (white)
- DRAW:
  - Pixel offsets px, py each 0..3; px increments fastest.
  - vga_x = GRID_OFFSET_X + cx*PIXEL_SIZE + px; vga_y = GRID_OFFSET_Y + cy*PIXEL_SIZE + py.
  - Maximum x and y are 121, within width.
- Latency, CELL mode: accept at cycle 0; first plot at cycle 3; last plot at cycle 18; IDLE and upd_ready=1 at cycle 19. That is 16 plots exactly.
- FULL mode:
  - After the cell's 16 plots, NEXT advances cx (wraps at 27→0 with cy+1), then returns to FETCH.
  - After cell (27,27), redraw_done pulses for 1 cycle in NEXT, then IDLE.
  - Cell cadence is 19 cycles; full redraw is 784 cells / 12544 plots.
- redraw_req arriving while busy:
  - Sets pending.
  - In FULL mode it restarts at (0,0) after the current cell completes; redraw_done fires only for the completed restart.
  - In CELL mode it is taken when IDLE is next reached.
- upd_x or upd_y >= GRID_SIZE: accepted (handshake completes), no plot, back to IDLE next cycle.
- Cursor is sampled per cell, so a cursor move during a redraw may leave the old cell red. Caller issues cell updates for the old and new cursor cells.
- vga_plot is never high outside DRAW; vga_x/vga_y/vga_colour hold their last values when idle.

Decomposition:
- Shared package vga_grid_pkg:
  - GRID_SIZE, PIXEL_SIZE, GRID_OFFSET_X/Y, grid cell count 784
  - colour constants COL_RED=3'b100, COL_BLACK=3'b000, COL_WHITE=3'b111
  - state encoding
- Sub-module grid_cell_painter:
  - Takes start, cx, cy, colour.
  - Runs the 4x4 px/py counter, drives vga_x/vga_y/vga_plot.
  - Returns a done pulse on the 16th plot.
- Scheduler keeps the arbitration FSM, pending flag, full-grid cell walker and memory fetch.

Test Plan:
- Reset: assert resetn=0 mid-DRAW → same cycle vga_plot=0, busy=0; after release upd_ready=1; no plot until a request.
- Cell update (0,0), mem_rdata=0, cursor (14,14) → plots cycles 3..18 covering x10..13, y10..13, colour 111; upd_ready=1 at cycle 19.
- Cell update (14,14) with cursor (14,14) → 16 plots at x66..69, y66..69, colour 100. Cell (5,2) with mem_rdata=1 → colour 000 at x30..33, y18..21, mem_addr=61.
- redraw_req with all memory 0 → 12544 plots, each cell exactly once, all 111; redraw_done single pulse; upd_ready low throughout.
- redraw_req again at plot 5000 → current cell finishes, walk restarts at (0,0), exactly one redraw_done. upd_valid held during redraw is accepted only after IDLE.
- Update (28,3) → handshake completes, zero plots, busy for 2 cycles only.
